// File: rtl/kpg_iter_adder_if.sv
// kpg_iter_adder_if
//   Start/busy/done handshake and data bus for the iterative KPG adder.
//   master: multiplier controller side (drives start, a, b, cin)
//   slave : adder side (drives busy, done, sum, cout)
//   Signals:
//     start - request to add, sampled on the rising clock edge
//     a, b  - WIDTH-bit operands, sampled with start
//     cin   - carry-in, sampled with start
//     busy  - carry resolution in progress
//     done  - one-cycle pulse, sum/cout valid from this cycle
//     sum   - registered WIDTH-bit sum, held until the next done
//     cout  - registered carry-out, held with sum
interface kpg_iter_adder_if #(
  parameter int WIDTH = 24
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/kpg_iter_adder.sv
// kpg_iter_adder
//   Iterative carry-resolution adder. One KPG combine level is reused over
//   STEPS log-distance prefix steps to resolve the whole carry vector, then
//   the sum and carry-out are registered.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - kpg_iter_adder_if slave modport (start/a/b/cin in,
//             busy/done/sum/cout out)
//   KPG code encoding {hi,lo}: 00 kill, 11 generate, 10 propagate.
module kpg_iter_adder #(
  parameter int WIDTH = 24
) (
  input logic            clk,
  input logic            rst_n,
  kpg_iter_adder_if.slave bus
);

  localparam int STEPS = $clog2(WIDTH + 1);
  localparam int KW    = $clog2(STEPS);

  localparam logic [1:0] KILL = 2'b00;
  localparam logic [1:0] GEN  = 2'b11;
  localparam logic [1:0] PROP = 2'b10;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PREFIX = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]           state;
  logic [KW-1:0]        k;
  logic [WIDTH-1:0]     p;
  logic [WIDTH:0][1:0]  c;
  logic [WIDTH-1:0]     sum_q;
  logic                 cout_q;

  logic [WIDTH:0][1:0]  init_codes;
  logic [WIDTH:0][1:0]  stepped;
  logic [WIDTH-1:0]     sum_next;

  // Initial code per bit: hi = a|b, lo = a&b gives K/P/G and never 01.
  // Entry 0 carries the carry-in as a plain G or K.
  always_comb begin
    init_codes    = '0;
    init_codes[0] = bus.cin ? GEN : KILL;
    for (int i = 0; i < WIDTH; i++) begin
      init_codes[i+1] = {bus.a[i] | bus.b[i], bus.a[i] & bus.b[i]};
    end
  end

  // One combine level. The distance is selected from compile-time constants
  // so each step becomes a fixed wiring pattern muxed by k. All reads come
  // from the pre-step array, so entries updated this step never feed others.
  always_comb begin
    stepped = c;
    for (int s = 0; s < STEPS; s++) begin
      if (k == KW'(s)) begin
        for (int j = (1 << s); j <= WIDTH; j++) begin
          if (c[j] == PROP) begin
            stepped[j] = c[j - (1 << s)];
          end
        end
      end
    end
  end

  // Once every entry is resolved, the lo bit of c[i] is the carry into bit i.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_next[i] = p[i] ^ stepped[i][0];
    end
  end

  // Control and datapath registers. The result registers load only on the
  // last prefix step, so they hold steady through idle and later busy time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      p      <= '0;
      c      <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state <= PREFIX;
            k     <= '0;
            p     <= bus.a ^ bus.b;
            c     <= init_codes;
          end else begin
            state <= IDLE;
          end
        end
        PREFIX: begin
          c <= stepped;
          if (k == KW'(STEPS - 1)) begin
            state  <= DONE;
            sum_q  <= sum_next;
            cout_q <= stepped[WIDTH][0];
          end else begin
            k <= k + KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == PREFIX);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
